// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, hit freeze, flush-to-bubble, saturating perf counters.
// Define PIPE_SKID_EN to add one skid entry (registered in_ready, states EMPTY/FULL/FULL2).
module pipe_stage_reg #(
   parameter int unsigned       CTRL_W      = 17,
   parameter int unsigned       PAYLOAD_W   = 122,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
   parameter int unsigned       CNT_W       = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 hit,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CTRL_W-1:0]    in_ctrl,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     bubble_cnt
);
   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_FULL2 = 2'd2} state_t;

   state_t                 state_r, state_nxt_s;
   logic                   out_valid_r;
   logic [CTRL_W-1:0]      out_ctrl_r;
   logic [PAYLOAD_W-1:0]   out_payload_r;
   logic [CNT_W-1:0]       stall_cnt_r, bubble_cnt_r;
   logic                   accept_s, release_s, load_in_s, stall_s;
   logic [1:0]             drop_s;
`ifdef PIPE_SKID_EN
   logic                   in_ready_r, load_skid_s, load_from_skid_s;
   logic [CTRL_W-1:0]      skid_ctrl_r;
   logic [PAYLOAD_W-1:0]   skid_payload_r;
`endif

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      if (sum > {1'b0, {CNT_W{1'b1}}}) sat_add = {CNT_W{1'b1}};
      else                             sat_add = sum[CNT_W-1:0];
   endfunction

`ifdef PIPE_SKID_EN
   assign in_ready = in_ready_r;
`else
   assign in_ready = ~out_valid_r | out_ready;
`endif
   assign accept_s    = in_valid & in_ready & hit;
   assign release_s   = out_valid_r & out_ready & hit;
   assign stall_s     = in_valid & ~in_ready;
   assign out_valid   = out_valid_r;
   assign out_ctrl    = out_ctrl_r;
   assign out_payload = out_payload_r;
   assign stall_cnt   = stall_cnt_r;
   assign bubble_cnt  = bubble_cnt_r;

   // Next-state and data-steering decode; flush overrides every handshake.
   always_comb begin
      state_nxt_s = state_r;
      load_in_s   = 1'b0;
      drop_s      = 2'd0;
`ifdef PIPE_SKID_EN
      load_skid_s      = 1'b0;
      load_from_skid_s = 1'b0;
`endif
      if (flush) begin
         state_nxt_s = ST_EMPTY;
         case (state_r)
            ST_FULL:  drop_s = 2'd1;
            ST_FULL2: drop_s = 2'd2;
            default:  drop_s = 2'd0;
         endcase
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_nxt_s = ST_FULL;
                  load_in_s   = 1'b1;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (accept_s && release_s) begin
                  state_nxt_s = ST_FULL;
                  load_in_s   = 1'b1;
`ifdef PIPE_SKID_EN
               end else if (accept_s) begin
                  state_nxt_s = ST_FULL2;
                  load_skid_s = 1'b1;
`endif
               end else if (release_s) begin
                  state_nxt_s = ST_EMPTY;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
`ifdef PIPE_SKID_EN
            ST_FULL2: begin
               if (release_s) begin
                  state_nxt_s      = ST_FULL;
                  load_from_skid_s = 1'b1;
               end else begin
                  state_nxt_s = ST_FULL2;
               end
            end
`endif
            default: state_nxt_s = ST_EMPTY;
         endcase
      end
   end

   // Stage state, output bundle, skid slot and perf counters; hit=0 freezes all of it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r       <= ST_EMPTY;
         out_valid_r   <= 1'b0;
         out_ctrl_r    <= BUBBLE_CTRL;
         out_payload_r <= {PAYLOAD_W{1'b0}};
         stall_cnt_r   <= {CNT_W{1'b0}};
         bubble_cnt_r  <= {CNT_W{1'b0}};
`ifdef PIPE_SKID_EN
         in_ready_r     <= 1'b1;
         skid_ctrl_r    <= {CTRL_W{1'b0}};
         skid_payload_r <= {PAYLOAD_W{1'b0}};
`endif
      end else if (hit) begin
         state_r     <= state_nxt_s;
         out_valid_r <= (state_nxt_s != ST_EMPTY);
         // Empty stage always presents the nop bundle so stale writes never leak downstream.
         if (state_nxt_s == ST_EMPTY) begin
            out_ctrl_r <= BUBBLE_CTRL;
         end else if (load_in_s) begin
            out_ctrl_r    <= in_ctrl;
            out_payload_r <= in_payload;
`ifdef PIPE_SKID_EN
         end else if (load_from_skid_s) begin
            out_ctrl_r    <= skid_ctrl_r;
            out_payload_r <= skid_payload_r;
`endif
         end
`ifdef PIPE_SKID_EN
         in_ready_r <= (state_nxt_s != ST_FULL2);
         if (load_skid_s) begin
            skid_ctrl_r    <= in_ctrl;
            skid_payload_r <= in_payload;
         end
`endif
         stall_cnt_r  <= sat_add(stall_cnt_r, {1'b0, stall_s});
         bubble_cnt_r <= sat_add(bubble_cnt_r, drop_s);
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand sequences, and a queue-based random model.
module tb_pipe_stage_reg;
   localparam int CTRL_W = 8, PAYLOAD_W = 16, CNT_W = 4;
   localparam int CNT_MAX = 15;
`ifdef PIPE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic                 CLK = 1'b0;
   logic                 RST, hit, flush, in_valid, in_ready, out_valid, out_ready;
   logic [CTRL_W-1:0]    in_ctrl, out_ctrl;
   logic [PAYLOAD_W-1:0] in_payload, out_payload;
   logic [CNT_W-1:0]     stall_cnt, bubble_cnt;
   int errors = 0, checks = 0;

   always #5 CLK = ~CLK;

   pipe_stage_reg #(.CTRL_W(CTRL_W), .PAYLOAD_W(PAYLOAD_W), .BUBBLE_CTRL(8'h00), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .hit(hit), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_payload(in_payload),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_payload(out_payload),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

   // ---------------- reference model: FIFO of capacity CAP ----------------
   typedef struct packed {logic [CTRL_W-1:0] c; logic [PAYLOAD_W-1:0] p;} ent_t;
   ent_t q[$];
   int   m_stall, m_bub;

   function automatic bit m_ready(input logic ordy);
      if (CAP == 2) return q.size() < 2;
      return (q.size() == 0) || ordy;
   endfunction

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic model_step(input logic h, f, iv, input logic [CTRL_W-1:0] c,
                             input logic [PAYLOAD_W-1:0] p, input logic ordy, input bit rdy);
      bit rel, acc;
      if (h) begin
         if (iv && !rdy) m_stall = sat(m_stall + 1);
         if (f) begin
            m_bub = sat(m_bub + q.size());
            q.delete();
         end else begin
            rel = (q.size() > 0) && ordy;
            acc = iv && rdy;
            if (rel) void'(q.pop_front());
            if (acc) q.push_back({c, p});
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic h, f, iv, input logic [CTRL_W-1:0] c,
                        input logic [PAYLOAD_W-1:0] p, input logic ordy);
      @(negedge CLK);
      hit = h; flush = f; in_valid = iv; in_ctrl = c; in_payload = p; out_ready = ordy;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; hit = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = 8'h00; in_payload = 16'h0000;
      @(negedge CLK);
      RST = 1'b0;
      q.delete(); m_stall = 0; m_bub = 0;
   endtask

   // ---------------- directed vector table (default build) ----------------
   typedef struct {
      logic h, f, iv; logic [CTRL_W-1:0] c; logic [PAYLOAD_W-1:0] p; logic ordy;
      logic ev; logic [CTRL_W-1:0] ec; logic [PAYLOAD_W-1:0] ep; int es, eb;
   } vec_t;
   vec_t tbl[17];

   function automatic vec_t mk(input logic h, f, iv, input logic [7:0] c, input logic [15:0] p, input logic ordy,
                               input logic ev, input logic [7:0] ec, input logic [15:0] ep, input int es, eb);
      vec_t v;
      v.h = h; v.f = f; v.iv = iv; v.c = c; v.p = p; v.ordy = ordy;
      v.ev = ev; v.ec = ec; v.ep = ep; v.es = es; v.eb = eb;
      return v;
   endfunction

   initial begin
      bit rdy;
      logic h, f, iv, ordy;
      logic [CTRL_W-1:0] c;
      logic [PAYLOAD_W-1:0] p;

      // streaming, backpressure, freeze, replace, flush, drain, flush-when-empty
      tbl[0] = mk(1'b1, 1'b0, 1'b1, 8'h11, 16'd1, 1'b1, 1'b1, 8'h11, 16'd1, 0, 0);
      tbl[1] = mk(1'b1, 1'b0, 1'b1, 8'h22, 16'd2, 1'b1, 1'b1, 8'h22, 16'd2, 0, 0);
      tbl[2] = mk(1'b1, 1'b0, 1'b1, 8'h33, 16'd3, 1'b1, 1'b1, 8'h33, 16'd3, 0, 0);
      for (int i = 0; i < 4; i++)
         tbl[3+i] = mk(1'b1, 1'b0, 1'b1, 8'h44, 16'd4, 1'b0, 1'b1, 8'h33, 16'd3, i + 1, 0);
      for (int i = 0; i < 5; i++)
         tbl[7+i] = mk(1'b0, 1'b1, 1'b1, 8'h55, 16'd5, 1'b1, 1'b1, 8'h33, 16'd3, 4, 0);
      tbl[12] = mk(1'b1, 1'b0, 1'b1, 8'h44, 16'd4, 1'b1, 1'b1, 8'h44, 16'd4, 4, 0);
      tbl[13] = mk(1'b1, 1'b1, 1'b1, 8'h55, 16'd5, 1'b0, 1'b0, 8'h00, 16'd0, 5, 1);
      tbl[14] = mk(1'b1, 1'b0, 1'b1, 8'h66, 16'd6, 1'b1, 1'b1, 8'h66, 16'd6, 5, 1);
      tbl[15] = mk(1'b1, 1'b0, 1'b0, 8'h77, 16'd7, 1'b1, 1'b0, 8'h00, 16'd0, 5, 1);
      tbl[16] = mk(1'b1, 1'b1, 1'b1, 8'h88, 16'd8, 1'b1, 1'b0, 8'h00, 16'd0, 5, 1);

      RST = 1'b1; hit = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = 8'h00; in_payload = 16'h0000;
      #2;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_ctrl", out_ctrl, 8'h00);
      check("reset_out_payload", out_payload, 16'h0000);
      check("reset_stall_cnt", stall_cnt, 4'd0);
      check("reset_bubble_cnt", bubble_cnt, 4'd0);
      check("reset_in_ready", in_ready, 1'b1);
      do_reset();

`ifndef PIPE_SKID_EN
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].h, tbl[i].f, tbl[i].iv, tbl[i].c, tbl[i].p, tbl[i].ordy);
         @(posedge CLK); #1;
         check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         check($sformatf("tbl%0d_ctrl", i), out_ctrl, tbl[i].ec);
         if (tbl[i].ev) check($sformatf("tbl%0d_payload", i), out_payload, tbl[i].ep);
         check($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].es);
         check($sformatf("tbl%0d_bubble", i), bubble_cnt, tbl[i].eb);
      end
`else
      // skid: fill FULL2 then flush discards two live entries
      drive(1'b1, 1'b0, 1'b1, 8'h11, 16'd1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 8'h22, 16'd2, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 8'h33, 16'd3, 1'b0);
      @(posedge CLK); #1;
      check("skid_flush_valid", out_valid, 1'b0);
      check("skid_flush_ctrl", out_ctrl, 8'h00);
      check("skid_flush_bubble", bubble_cnt, 4'd2);
`endif

      // reset mid-stream while FULL with nonzero stall count
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 8'hA5, 16'h1234, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 8'hA6, 16'h1235, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 8'hA6, 16'h1235, 1'b0);
      @(posedge CLK); #1;
      check("pre_reset_valid", out_valid, 1'b1);
      check("pre_reset_stall_nonzero", (stall_cnt != 4'd0), 1'b1);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("midreset_valid", out_valid, 1'b0);
      check("midreset_ctrl", out_ctrl, 8'h00);
      check("midreset_stall", stall_cnt, 4'd0);
      check("midreset_bubble", bubble_cnt, 4'd0);

      // saturation: 20 blocked cycles
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 8'h5A, 16'h00AA, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b1, 8'h5B, 16'h00BB, 1'b0);
      @(posedge CLK); #1;
      check("sat_stall", stall_cnt, 4'd15);
      check("sat_out_held", out_payload, 16'h00AA);

      // randomized run against the FIFO model
      do_reset();
      for (int n = 0; n < 600; n++) begin
         h    = ($urandom_range(0, 7) != 0);
         f    = ($urandom_range(0, 15) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         c    = CTRL_W'($urandom);
         p    = PAYLOAD_W'($urandom);
         drive(h, f, iv, c, p, ordy);
         #1;
         rdy = m_ready(ordy);
         check("rnd_in_ready", in_ready, rdy);
         @(posedge CLK);
         model_step(h, f, iv, c, p, ordy, rdy);
         #1;
         check("rnd_valid", out_valid, (q.size() > 0));
         check("rnd_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : 8'h00);
         if (q.size() > 0) check("rnd_payload", out_payload, q[0].p);
         check("rnd_stall", stall_cnt, m_stall);
         check("rnd_bubble", bubble_cnt, m_bub);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
